// File: rtl/romulator_pkg.sv
// rtl/romulator_pkg.sv - shared boot-sequencer states, RAM port owners and image size
package romulator_pkg;

   localparam int unsigned IMAGE_BYTES = 65536;

   typedef enum logic [2:0] {
      LOAD,
      CK_READ,
      CK_ACC,
      HOLD,
      RUN
   } boot_state_e;

   typedef enum logic [1:0] {
      OWN_LOADER,
      OWN_CHECKER,
      OWN_IDLE,
      OWN_CPU
   } port_owner_e;

   function automatic port_owner_e owner_of(boot_state_e s);
      case (s)
         LOAD:    return OWN_LOADER;
         CK_READ: return OWN_CHECKER;
         RUN:     return OWN_CPU;
         default: return OWN_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/cpu_boot_sequencer_sync_bit.sv
// rtl/cpu_boot_sequencer_sync_bit.sv - multi-flop single-bit synchronizer
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_boot_sequencer.sv
// rtl/cpu_boot_sequencer.sv - holds the CPU in reset until the loaded image has been summed
module cpu_boot_sequencer
   import romulator_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES = 16,
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned CHECK_BYTES       = IMAGE_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_complete,
   input  logic [15:0] ldr_ram_address,
   input  logic [7:0]  ldr_ram_datain,
   input  logic        ldr_ram_cs,
   input  logic        ldr_ram_we,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_datain,
   input  logic        cpu_cs,
   input  logic        cpu_we,
   input  logic [7:0]  ram_dataout,
   output logic [15:0] ram_address,
   output logic [7:0]  ram_datain,
   output logic        ram_cs,
   output logic        ram_we,
   input  logic [15:0] expected_sum,
   output logic        cpu_reset_n,
   output logic [15:0] checksum,
   output logic        checksum_valid,
   output logic        checksum_ok
);

   // A zero hold request still spends one clock in HOLD.
   localparam logic [31:0] HOLD_LOAD = (RESET_HOLD_CYCLES == 0) ? 32'd1 : 32'(RESET_HOLD_CYCLES);
   localparam logic [16:0] ADDR_END  = 17'(CHECK_BYTES);

   boot_state_e state_q;
   port_owner_e owner;
   logic [16:0] addr_q;
   logic [16:0] addr_d;
   logic [15:0] sum_q;
   logic [15:0] sum_d;
   logic [31:0] hold_q;
   logic        cpu_reset_n_q;
   logic        sum_valid_q;
   logic        sum_ok_q;
   logic        rc_s;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_rc_sync (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .d_i     (read_complete),
      .q_o     (rc_s)
   );

   assign addr_d = addr_q + 17'd1;
   assign sum_d  = sum_q + {8'h00, ram_dataout};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= LOAD;
         addr_q        <= '0;
         sum_q         <= '0;
         hold_q        <= '0;
         cpu_reset_n_q <= 1'b0;
         sum_valid_q   <= 1'b0;
         sum_ok_q      <= 1'b0;
      end else begin
         cpu_reset_n_q <= (state_q == RUN);
         case (state_q)
            LOAD: begin
               if (rc_s) begin
                  state_q <= CK_READ;
                  addr_q  <= '0;
                  sum_q   <= '0;
               end
            end
            CK_READ: begin
               state_q <= CK_ACC;
            end
            CK_ACC: begin
               sum_q  <= sum_d;
               addr_q <= addr_d;
               if (addr_d < ADDR_END) begin
                  state_q <= CK_READ;
               end else begin
                  state_q     <= HOLD;
                  sum_valid_q <= 1'b1;
                  sum_ok_q    <= (sum_d == expected_sum);
                  hold_q      <= HOLD_LOAD;
               end
            end
            HOLD: begin
               hold_q <= hold_q - 32'd1;
               if (hold_q == 32'd1) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   // Whoever does not own the port is simply not connected, so stray cs/we never reach the RAM.
   always_comb begin
      owner       = owner_of(state_q);
      ram_address = '0;
      ram_datain  = '0;
      ram_cs      = 1'b0;
      ram_we      = 1'b0;
      case (owner)
         OWN_LOADER: begin
            ram_address = ldr_ram_address;
            ram_datain  = ldr_ram_datain;
            ram_cs      = ldr_ram_cs;
            ram_we      = ldr_ram_we;
         end
         OWN_CHECKER: begin
            ram_address = addr_q[15:0];
            ram_cs      = 1'b1;
         end
         OWN_CPU: begin
            ram_address = cpu_address;
            ram_datain  = cpu_datain;
            ram_cs      = cpu_cs;
            ram_we      = cpu_we;
         end
         default: begin
            ram_cs = 1'b0;
         end
      endcase
   end

   assign cpu_reset_n    = cpu_reset_n_q;
   assign checksum       = sum_q;
   assign checksum_valid = sum_valid_q;
   assign checksum_ok    = sum_ok_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// tb/tb_cpu_boot_sequencer.sv - scoreboarded random bench for cpu_boot_sequencer
module tb_cpu_boot_sequencer;

   localparam int N    = 512;
   localparam int HOLD = 16;
   localparam int SYNC = 2;

   logic        clk             = 1'b0;
   logic        rst_n           = 1'b0;
   logic        read_complete   = 1'b0;
   logic [15:0] ldr_ram_address = '0;
   logic [7:0]  ldr_ram_datain  = '0;
   logic        ldr_ram_cs      = 1'b0;
   logic        ldr_ram_we      = 1'b0;
   logic [15:0] cpu_address     = '0;
   logic [7:0]  cpu_datain      = '0;
   logic        cpu_cs          = 1'b0;
   logic        cpu_we          = 1'b0;
   logic [7:0]  ram_dataout     = '0;
   logic [15:0] expected_sum    = '0;

   logic [15:0] ram_address;
   logic [7:0]  ram_datain;
   logic        ram_cs;
   logic        ram_we;
   logic        cpu_reset_n;
   logic [15:0] checksum;
   logic        checksum_valid;
   logic        checksum_ok;

   logic [15:0] ram_address0;
   logic [7:0]  ram_datain0;
   logic        ram_cs0;
   logic        ram_we0;
   logic        cpu_reset_n0;
   logic [15:0] checksum0;
   logic        checksum_valid0;
   logic        checksum_ok0;

   cpu_boot_sequencer #(
      .RESET_HOLD_CYCLES (HOLD),
      .SYNC_STAGES       (SYNC),
      .CHECK_BYTES       (N)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .read_complete   (read_complete),
      .ldr_ram_address (ldr_ram_address),
      .ldr_ram_datain  (ldr_ram_datain),
      .ldr_ram_cs      (ldr_ram_cs),
      .ldr_ram_we      (ldr_ram_we),
      .cpu_address     (cpu_address),
      .cpu_datain      (cpu_datain),
      .cpu_cs          (cpu_cs),
      .cpu_we          (cpu_we),
      .ram_dataout     (ram_dataout),
      .ram_address     (ram_address),
      .ram_datain      (ram_datain),
      .ram_cs          (ram_cs),
      .ram_we          (ram_we),
      .expected_sum    (expected_sum),
      .cpu_reset_n     (cpu_reset_n),
      .checksum        (checksum),
      .checksum_valid  (checksum_valid),
      .checksum_ok     (checksum_ok)
   );

   // Zero-hold twin runs in lock-step; its RAM traffic matches dut's whenever the CPU port is idle.
   cpu_boot_sequencer #(
      .RESET_HOLD_CYCLES (0),
      .SYNC_STAGES       (SYNC),
      .CHECK_BYTES       (N)
   ) dut0 (
      .clk             (clk),
      .rst_n           (rst_n),
      .read_complete   (read_complete),
      .ldr_ram_address (ldr_ram_address),
      .ldr_ram_datain  (ldr_ram_datain),
      .ldr_ram_cs      (ldr_ram_cs),
      .ldr_ram_we      (ldr_ram_we),
      .cpu_address     (cpu_address),
      .cpu_datain      (cpu_datain),
      .cpu_cs          (cpu_cs),
      .cpu_we          (cpu_we),
      .ram_dataout     (ram_dataout),
      .ram_address     (ram_address0),
      .ram_datain      (ram_datain0),
      .ram_cs          (ram_cs0),
      .ram_we          (ram_we0),
      .expected_sum    (expected_sum),
      .cpu_reset_n     (cpu_reset_n0),
      .checksum        (checksum0),
      .checksum_valid  (checksum_valid0),
      .checksum_ok     (checksum_ok0)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) mem[ram_address] <= ram_datain;
         ram_dataout <= mem[ram_address];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int          ref_cyc;
      logic [15:0] sum;
      logic        ok;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] img [0:N-1];

   function automatic logic [15:0] image_sum();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(img[i]);
      return s[15:0];
   endfunction

   int ph = 0;
   int start_cyc = 0;
   int valid_cyc = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         ph = 0;
      end else begin
         case (ph)
            0: if (exp_q.size() > 0 && ram_cs && !ram_we && !ldr_ram_cs && ram_address == 16'h0000) begin
                  chk("start_latency", 32'(cyc - exp_q[0].ref_cyc), SYNC + 1);
                  start_cyc = cyc;
                  ph = 1;
               end
            1: if (checksum_valid) begin
                  chk("check_cycles", 32'(cyc - start_cyc), 2 * N);
                  chk("checksum", 32'(checksum), 32'(exp_q[0].sum));
                  chk("checksum_ok", 32'(checksum_ok), 32'(exp_q[0].ok));
                  chk("cpu_held_at_hold", 32'(cpu_reset_n), 0);
                  valid_cyc = cyc;
                  ph = 2;
               end
            2: if (cpu_reset_n) begin
                  chk("hold_cycles", 32'(cyc - valid_cyc), HOLD + 1);
                  void'(exp_q.pop_front());
                  ph = 0;
               end
            default: ph = 0;
         endcase
      end
   end

   int   v0_cyc  = 0;
   logic v0_prev = 1'b0;
   logic r0_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         v0_prev = 1'b0;
         r0_prev = 1'b0;
      end else begin
         if (checksum_valid0 && !v0_prev) begin
            v0_cyc = cyc;
            chk("sb_entry_hold0", 32'(exp_q.size()), 1);
            if (exp_q.size() > 0) chk("checksum_hold0", 32'(checksum0), 32'(exp_q[0].sum));
         end
         if (cpu_reset_n0 && !r0_prev) chk("hold0_cycles", 32'(cyc - v0_cyc), 2);
         v0_prev = checksum_valid0;
         r0_prev = cpu_reset_n0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart();
      rst_n = 1'b0;
      read_complete = 1'b0;
      exp_q.delete();
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic load_image();
      for (int i = 0; i < N; i++) begin
         ldr_ram_address = 16'(i);
         ldr_ram_datain  = img[i];
         ldr_ram_cs      = 1'b1;
         ldr_ram_we      = 1'b1;
         step(1);
      end
      ldr_ram_cs = 1'b0;
      ldr_ram_we = 1'b0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.ref_cyc = cyc;
      e.sum     = image_sum();
      e.ok      = (e.sum == expected_sum);
      exp_q.push_back(e);
   endtask

   task automatic start_check();
      push_exp();
      read_complete = 1'b1;
      step(1 + $urandom_range(0, 3));
      read_complete = 1'b0;
   endtask

   task automatic wait_run();
      int budget = 2 * N + HOLD + 64;
      while (!cpu_reset_n && budget > 0) begin
         step(1);
         budget--;
      end
      chk("run_reached", 32'(cpu_reset_n), 1);
      step(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      step(1);
      chk("reset_cpu_reset_n", 32'(cpu_reset_n), 0);
      chk("reset_checksum", 32'(checksum), 0);
      chk("reset_valid", 32'(checksum_valid), 0);
      chk("reset_ok", 32'(checksum_ok), 0);
      for (int k = 0; k < 4; k++) begin
         ldr_ram_address = 16'($urandom);
         ldr_ram_datain  = 8'($urandom);
         ldr_ram_cs      = 1'($urandom);
         ldr_ram_we      = 1'($urandom);
         cpu_cs          = 1'($urandom);
         #1;
         chk("reset_mux_addr", 32'(ram_address), 32'(ldr_ram_address));
         chk("reset_mux_data", 32'(ram_datain), 32'(ldr_ram_datain));
         chk("reset_mux_cs", 32'(ram_cs), 32'(ldr_ram_cs));
         chk("reset_mux_we", 32'(ram_we), 32'(ldr_ram_we));
         step(1);
      end
      ldr_ram_cs = 1'b0;
      ldr_ram_we = 1'b0;
      cpu_cs     = 1'b0;

      // all-ones image
      restart();
      for (int i = 0; i < N; i++) img[i] = 8'h01;
      load_image();
      expected_sum = 16'(N);
      start_check();
      wait_run();

      // ramp image, matching then off-by-one reference
      for (int pass = 0; pass < 2; pass++) begin
         restart();
         for (int i = 0; i < N; i++) img[i] = 8'(i);
         load_image();
         expected_sum = image_sum() + 16'(pass);
         start_check();
         wait_run();
      end

      // random images, reference right half the time
      for (int r = 0; r < 3; r++) begin
         restart();
         for (int i = 0; i < N; i++) img[i] = 8'($urandom);
         load_image();
         expected_sum = ($urandom_range(0, 1) == 1) ? image_sum() : image_sum() ^ 16'($urandom_range(1, 65535));
         start_check();
         wait_run();
      end

      // port ownership: loader only in LOAD, CPU only in RUN
      restart();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      img[16] = 8'h12;
      load_image();
      ldr_ram_address = 16'h1234; ldr_ram_datain = 8'hAA; ldr_ram_cs = 1'b1; ldr_ram_we = 1'b1;
      step(1);
      ldr_ram_cs = 1'b0; ldr_ram_we = 1'b0;
      step(1);
      chk("loader_write_load", 32'(mem[16'h1234]), 32'h0000_00AA);
      expected_sum = image_sum();
      start_check();
      cpu_address = 16'h0010; cpu_datain = 8'h55; cpu_cs = 1'b1; cpu_we = 1'b1;
      step(24);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      wait_run();
      chk("cpu_write_ignored", 32'(mem[16'h0010]), 32'h0000_0012);
      ldr_ram_address = 16'h1234; ldr_ram_datain = 8'h33; ldr_ram_cs = 1'b1; ldr_ram_we = 1'b1;
      step(1);
      ldr_ram_cs = 1'b0; ldr_ram_we = 1'b0;
      step(1);
      chk("loader_write_run", 32'(mem[16'h1234]), 32'h0000_00AA);
      cpu_address = 16'h0010; cpu_datain = 8'h55; cpu_cs = 1'b1; cpu_we = 1'b1;
      step(1);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      step(1);
      chk("cpu_write_run", 32'(mem[16'h0010]), 32'h0000_0055);

      // reset in CK_ACC half way, then rc held high through release
      restart();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom);
      load_image();
      expected_sum = image_sum();
      start_check();
      begin
         int budget = 4 * N;
         logic found = 1'b0;
         while (!found && budget > 0) begin
            step(1);
            budget--;
            if (ram_cs && !ram_we && ram_address == 16'(N / 2)) found = 1'b1;
         end
         chk("abort_point_found", 32'(found), 1);
      end
      step(1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_cpu_reset_n", 32'(cpu_reset_n), 0);
      chk("abort_checksum", 32'(checksum), 0);
      chk("abort_valid", 32'(checksum_valid), 0);
      chk("abort_ram_cs", 32'(ram_cs), 32'(ldr_ram_cs));
      read_complete = 1'b1;
      step(2);
      rst_n = 1'b1;
      push_exp();
      wait_run();
      read_complete = 1'b0;
      step(6);
      chk("run_sticky", 32'(cpu_reset_n), 1);
      chk("run_sticky_valid", 32'(checksum_valid), 1);

      step(3);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
